// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg: opcodes, FSM state encodings and field widths shared by the debug loader.
package mips_dbg_pkg;
  localparam int NB_OP = 3;
  localparam int NB_ST = 3;
  localparam logic [NB_OP-1:0] OP_NOP      = 3'd0;
  localparam logic [NB_OP-1:0] OP_WR_INST  = 3'd1;
  localparam logic [NB_OP-1:0] OP_WR_REG   = 3'd2;
  localparam logic [NB_OP-1:0] OP_RUN      = 3'd3;
  localparam logic [NB_OP-1:0] OP_STEP     = 3'd4;
  localparam logic [NB_OP-1:0] OP_STOP     = 3'd5;
  localparam logic [NB_OP-1:0] OP_SET_PC   = 3'd6;
  localparam logic [NB_OP-1:0] OP_SET_BKPT = 3'd7;
  typedef enum logic [NB_ST-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_HALTED = 3'd3
  } state_t;
endpackage

// File: rtl/mips_sat_counter.sv
// mips_sat_counter: up-counter that sticks at all-ones, with synchronous clear and async reset.
module mips_sat_counter #(
  parameter int NB_CNT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              increment,
  output logic [NB_CNT-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clear) count <= '0;
    else if (increment && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/mips_debug_loader.sv
// mips_debug_loader: command-stream debug/load controller in front of the MIPS core.
// Optional breakpoint support is built when MIPS_DBG_BREAKPOINT_EN is defined.
module mips_debug_loader
  import mips_dbg_pkg::*;
#(
  parameter int                 NB_INST    = 32,
  parameter int                 NB_ADDR    = 32,
  parameter int                 NB_DATA    = 32,
  parameter int                 NB_REG     = 5,
  parameter int                 IMEM_DEPTH = 256,
  parameter int                 NB_CNT     = 32,
  parameter logic [NB_INST-1:0] HALT_WORD  = 32'h0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [NB_OP-1:0]   i_cmd_op,
  input  logic [NB_ADDR-1:0] i_cmd_addr,
  input  logic [NB_DATA-1:0] i_cmd_data,
  input  logic [NB_INST-1:0] i_core_instruction,
  input  logic [NB_ADDR-1:0] i_core_pc,
  output logic               o_enable,
  output logic               o_imem_write,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_INST-1:0] o_imem_data,
  output logic               o_rf_write,
  output logic [NB_REG-1:0]  o_rf_addr,
  output logic [NB_DATA-1:0] o_rf_data,
  output logic               o_pc_load,
  output logic [NB_ADDR-1:0] o_pc_value,
  output logic [NB_ST-1:0]   o_state,
  output logic               o_halted,
  output logic               o_error,
  output logic               o_break,
  output logic [NB_CNT-1:0]  o_cycle_count
);
  state_t state;
  logic accept, idle_like, svc, in_range, halt_seen, bkpt_hit, err_set, set_pc;
  assign o_state     = state;
  assign o_cmd_ready = state != ST_STEP;
  assign o_enable    = state == ST_RUN || state == ST_STEP;
  assign o_halted    = state == ST_HALTED;
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign idle_like   = state == ST_IDLE || state == ST_HALTED;
  assign svc         = accept && idle_like;
  assign in_range    = i_cmd_addr < NB_ADDR'(IMEM_DEPTH);
  assign halt_seen   = o_enable && i_core_instruction == HALT_WORD;
  assign set_pc      = svc && i_cmd_op == OP_SET_PC;
`ifdef MIPS_DBG_BREAKPOINT_EN
  localparam bit BKPT_EN = 1'b1;
  logic [NB_ADDR-1:0] bkpt_addr;
  logic               bkpt_valid;
  assign bkpt_hit = state == ST_RUN && bkpt_valid && i_core_pc == bkpt_addr && !halt_seen;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      bkpt_addr  <= '0;
      bkpt_valid <= 1'b0;
      o_break    <= 1'b0;
    end else begin
      o_break <= bkpt_hit;
      if (svc && i_cmd_op == OP_SET_BKPT) begin
        bkpt_addr  <= i_cmd_addr;
        bkpt_valid <= i_cmd_data[0];
      end
    end
`else
  localparam bit BKPT_EN = 1'b0;
  logic unused_ok;
  assign unused_ok = ^i_core_pc;
  assign bkpt_hit  = 1'b0;
  assign o_break   = 1'b0;
`endif
  // In RUN only STOP/NOP are legal; elsewhere legality depends on range, state and build.
  assign err_set = accept && (state == ST_RUN ? i_cmd_op != OP_STOP && i_cmd_op != OP_NOP
    : (i_cmd_op == OP_WR_INST && !in_range)
      || (state == ST_HALTED && (i_cmd_op == OP_RUN || i_cmd_op == OP_STEP))
      || (i_cmd_op == OP_SET_BKPT && !BKPT_EN));
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state        <= ST_IDLE;
      o_imem_write <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_data  <= '0;
      o_rf_write   <= 1'b0;
      o_rf_addr    <= '0;
      o_rf_data    <= '0;
      o_pc_load    <= 1'b0;
      o_pc_value   <= '0;
      o_error      <= 1'b0;
    end else begin
      o_imem_write <= svc && i_cmd_op == OP_WR_INST && in_range;
      o_rf_write   <= svc && i_cmd_op == OP_WR_REG;
      o_pc_load    <= set_pc;
      if (svc && i_cmd_op == OP_WR_INST) begin
        o_imem_addr <= i_cmd_addr;
        o_imem_data <= NB_INST'(i_cmd_data);
      end
      if (svc && i_cmd_op == OP_WR_REG) begin
        o_rf_addr <= i_cmd_addr[NB_REG-1:0];
        o_rf_data <= i_cmd_data;
      end
      if (set_pc) o_pc_value <= NB_ADDR'(i_cmd_data);
      o_error <= set_pc ? 1'b0 : o_error | err_set;
      if (halt_seen) state <= ST_HALTED;
      else if (bkpt_hit || state == ST_STEP) state <= ST_IDLE;
      else if (state == ST_RUN) state <= accept && i_cmd_op == OP_STOP ? ST_IDLE : ST_RUN;
      else if (accept && state == ST_IDLE && i_cmd_op == OP_RUN) state <= ST_RUN;
      else if (accept && state == ST_IDLE && i_cmd_op == OP_STEP) state <= ST_STEP;
      else if (set_pc) state <= ST_IDLE;
    end
  mips_sat_counter #(.NB_CNT(NB_CNT)) u_cnt (
    .clk(i_clk),
    .rst(i_reset),
    .clear(set_pc),
    .increment(o_enable),
    .count(o_cycle_count)
  );
endmodule

// File: tb/tb_mips_debug_loader.sv
// tb_mips_debug_loader: directed vector table, hand sequences and a randomized model check
// for mips_debug_loader (breakpoint expectations follow MIPS_DBG_BREAKPOINT_EN).
module tb_mips_debug_loader;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int IMEM = 256;
`ifdef MIPS_DBG_BREAKPOINT_EN
  localparam bit BK = 1'b1;
`else
  localparam bit BK = 1'b0;
`endif
  localparam logic [2:0] NOP = 0, WRI = 1, WRR = 2, RUN = 3, STP = 4, STOP = 5, SPC = 6, BKP = 7;
  logic clk = 0, rst = 1, v = 0;
  logic [2:0] op = 0;
  logic [31:0] a = 0, d = 0, ins = 32'h1, pc = 0;
  logic rdy, en, iw, rw, pl, hl, er, brk;
  logic [31:0] ia, id, rd, pv;
  logic [4:0] ra;
  logic [2:0] st;
  logic [CW-1:0] cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mips_debug_loader #(.NB_CNT(CW)) dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(v), .o_cmd_ready(rdy), .i_cmd_op(op),
    .i_cmd_addr(a), .i_cmd_data(d), .i_core_instruction(ins), .i_core_pc(pc),
    .o_enable(en), .o_imem_write(iw), .o_imem_addr(ia), .o_imem_data(id),
    .o_rf_write(rw), .o_rf_addr(ra), .o_rf_data(rd), .o_pc_load(pl), .o_pc_value(pv),
    .o_state(st), .o_halted(hl), .o_error(er), .o_break(brk), .o_cycle_count(cnt));
  typedef struct {
    logic v; logic [2:0] op; logic [31:0] a, d, ins, pc;
    int st; bit en, iw, rw, pl, er, bk; int cnt;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic v, logic [2:0] op, logic [31:0] a, d, ins, pc,
                              int st, bit en, iw, rw, pl, er, bk, int cnt);
    vec_t r;
    r.v = v; r.op = op; r.a = a; r.d = d; r.ins = ins; r.pc = pc;
    r.st = st; r.en = en; r.iw = iw; r.rw = rw; r.pl = pl; r.er = er; r.bk = bk; r.cnt = cnt;
    return r;
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic vv, input logic [2:0] o, input logic [31:0] aa, dd, ii, pp);
    v = vv; op = o; a = aa; d = dd; ins = ii; pc = pp;
  endtask
  // reference model state: mode 0 idle, 1 run, 2 step, 3 halted
  int m_mode, m_cnt;
  bit m_err, bv, e_iw, e_rw, e_pl, e_bk;
  logic [31:0] ba, e_ia, e_id, e_rd, e_pv;
  logic [4:0] e_ra;
  task automatic model(input logic mv, input logic [2:0] mo, input logic [31:0] ma, md, mi, mp);
    bit men, acc, idl, halt, hit;
    int nx;
    men = m_mode == 1 || m_mode == 2;
    acc = mv && m_mode != 2;
    idl = m_mode == 0 || m_mode == 3;
    halt = men && mi == 32'h0;
    hit = BK && m_mode == 1 && bv && mp == ba && !halt;
    e_iw = 0; e_rw = 0; e_pl = 0; e_bk = hit; nx = m_mode;
    if (men && m_cnt < CMAX) m_cnt++;
    if (acc && m_mode == 1 && mo != STOP && mo != NOP) m_err = 1;
    if (acc && idl) begin
      if (mo == WRI) begin
        if (ma < IMEM) begin e_iw = 1; e_ia = ma; e_id = md; end
        else m_err = 1;
      end
      if (mo == WRR) begin e_rw = 1; e_ra = ma[4:0]; e_rd = md; end
      if (mo == SPC) begin e_pl = 1; e_pv = md; m_cnt = 0; m_err = 0; nx = 0; end
      if (mo == RUN || mo == STP) begin
        if (m_mode == 0) nx = mo == RUN ? 1 : 2;
        else m_err = 1;
      end
      if (mo == BKP) begin
        if (BK) begin ba = ma; bv = md[0]; end
        else m_err = 1;
      end
    end
    if (halt) nx = 3;
    else if (hit || m_mode == 2) nx = 0;
    else if (m_mode == 1 && acc && mo == STOP) nx = 0;
    m_mode = nx;
  endtask
  initial begin
    // load, range, run-to-halt, step, collision, breakpoint / illegal op 7
    tbl.push_back(mk(1, WRR, 1, 1, 1, 0,            0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, WRR, 2, 2, 1, 0,            0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, WRI, 1, 32'h00221020, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, NOP, 0, 0, 1, 0,            0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, WRI, 256, 5, 1, 0,          0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, SPC, 0, 0, 1, 0,            0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, RUN, 0, 0, 1, 0,            1, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk(0, NOP, 0, 0, 1, 0,          1, 1, 0, 0, 0, 0, 0, i));
    tbl.push_back(mk(0, NOP, 0, 0, 0, 0,            3, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk(1, RUN, 0, 0, 0, 0,            3, 0, 0, 0, 0, 1, 0, 5));
    tbl.push_back(mk(1, WRR, 3, 7, 0, 0,            3, 0, 0, 1, 0, 1, 0, 5));
    tbl.push_back(mk(1, SPC, 0, 0, 1, 0,            0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, STP, 0, 0, 1, 0,            2, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, NOP, 0, 0, 1, 0,            0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, STP, 0, 0, 1, 0,            2, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, RUN, 0, 0, 1, 0,            0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, STP, 0, 0, 1, 0,            2, 1, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, NOP, 0, 0, 1, 0,            0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, RUN, 0, 0, 1, 0,            1, 1, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, STOP, 0, 0, 0, 0,           3, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, SPC, 0, 0, 1, 0,            0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, BKP, 8, 1, 1, 0,            0, 0, 0, 0, 0, !BK, 0, 0));
    tbl.push_back(mk(1, RUN, 0, 0, 1, 0,            1, 1, 0, 0, 0, !BK, 0, 0));
    tbl.push_back(mk(0, NOP, 0, 0, 1, 4,            1, 1, 0, 0, 0, !BK, 0, 1));
    tbl.push_back(mk(0, NOP, 0, 0, 1, 8,            BK ? 0 : 1, !BK, 0, 0, 0, !BK, BK, 2));
    tbl.push_back(mk(0, NOP, 0, 0, 1, 8,            BK ? 0 : 1, !BK, 0, 0, 0, !BK, 0, BK ? 2 : 3));
    tbl.push_back(mk(1, STOP, 0, 0, 1, 8,           0, 0, 0, 0, 0, !BK, 0, BK ? 2 : 4));
    tick;
    chk("reset_state", {st, en, iw, rw, pl, hl, er, brk, 28'(cnt)}, 0);
    chk("reset_ready", rdy, 1);
    rst = 0;
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].ins, tbl[i].pc);
      tick;
      chk($sformatf("r%0d_state", i), st, tbl[i].st);
      chk($sformatf("r%0d_enable", i), en, tbl[i].en);
      chk($sformatf("r%0d_ready", i), rdy, tbl[i].st != 2);
      chk($sformatf("r%0d_halted", i), hl, tbl[i].st == 3);
      chk($sformatf("r%0d_strobes", i), {iw, rw, pl}, {tbl[i].iw, tbl[i].rw, tbl[i].pl});
      chk($sformatf("r%0d_error", i), er, tbl[i].er);
      chk($sformatf("r%0d_break", i), brk, tbl[i].bk);
      chk($sformatf("r%0d_count", i), cnt, tbl[i].cnt);
      if (tbl[i].iw) chk($sformatf("r%0d_imem", i), {ia, id}, {tbl[i].a, tbl[i].d});
      if (tbl[i].rw) chk($sformatf("r%0d_rf", i), {ra, rd}, {tbl[i].a[4:0], tbl[i].d});
      if (tbl[i].pl) chk($sformatf("r%0d_pc", i), pv, tbl[i].d);
    end
    // saturation: long run without HALT
    drive(1, SPC, 0, 0, 1, 32'h100); tick;
    drive(1, RUN, 0, 0, 1, 32'h100); tick;
    drive(0, NOP, 0, 0, 1, 32'h100);
    for (int i = 0; i < 20; i++) tick;
    chk("sat_count", cnt, CMAX);
    chk("sat_state", st, 1);
    // asynchronous reset mid-RUN, checked before any clock edge
    #2 rst = 1;
    #1;
    chk("async_rst_enable", en, 0);
    chk("async_rst_outputs", {st, iw, rw, pl, hl, er, brk, 28'(cnt)}, 0);
    tick;
    rst = 0;
    m_mode = 0; m_cnt = 0; m_err = 0; bv = 0; ba = 0;
    for (int i = 0; i < 500; i++) begin
      logic rv; logic [2:0] ro; logic [31:0] ra_, rd_, ri, rp;
      rv = $urandom_range(0, 9) < 7;
      ro = 3'($urandom_range(0, 7));
      ra_ = $urandom_range(0, 9) < 8 ? 32'($urandom_range(0, 255)) : 32'($urandom_range(256, 400));
      rd_ = $urandom;
      ri = $urandom_range(0, 9) == 0 ? 32'h0 : $urandom | 32'h1;
      rp = 32'($urandom_range(0, 3) * 4);
      drive(rv, ro, ra_, rd_, ri, rp);
      model(rv, ro, ra_, rd_, ri, rp);
      tick;
      chk($sformatf("rnd%0d_state", i), st, m_mode);
      chk($sformatf("rnd%0d_flags", i), {en, rdy, hl, er, brk},
          {m_mode == 1 || m_mode == 2, m_mode != 2, m_mode == 3, m_err, e_bk});
      chk($sformatf("rnd%0d_count", i), cnt, m_cnt);
      chk($sformatf("rnd%0d_strobes", i), {iw, rw, pl}, {e_iw, e_rw, e_pl});
      if (e_iw) chk($sformatf("rnd%0d_imem", i), {ia, id}, {e_ia, e_id});
      if (e_rw) chk($sformatf("rnd%0d_rf", i), {ra, rd}, {e_ra, e_rd});
      if (e_pl) chk($sformatf("rnd%0d_pc", i), pv, e_pv);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
